// File: rtl/video_timing_if.sv
// video_timing_if: run request in, timing/position outputs back to the sink
// Ports (master = timing generator side):
//   en           run request into the generator
//   blanking     1 outside the active area
//   c0, c1       hsync / vsync levels
//   de           active video, inverse of blanking
//   x, y         pixel column / line, zero outside active area
//   frame_start  one-cycle pulse at position (0,0)
//   running      generator is producing frames
interface video_timing_if;
    logic        en;
    logic        blanking;
    logic        c0;
    logic        c1;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        frame_start;
    logic        running;
    modport master (input en, output blanking, c0, c1, de, x, y, frame_start, running);
    modport slave (output en, input blanking, c0, c1, de, x, y, frame_start, running);
endinterface

// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: raster timing generator with graceful end-of-frame stop
// Ports:
//   clk  pixel clock
//   rst  synchronous active-low reset
//   vif  video_timing_if.master: en in; blanking, c0 (hsync), c1 (vsync), de,
//        x, y, frame_start, running out, all registered from (state, h, v)
module video_timing_ctrl #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic H_POL    = 1'b0,
    parameter logic V_POL    = 1'b0
) (
    input logic             clk,
    input logic             rst,
    video_timing_if.master  vif
);
    localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
    localparam logic [11:0] HS_LO  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_HI  = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_LO  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_HI  = 12'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t      state, state_nx;
    logic [11:0] h_cnt, v_cnt, h_nx, v_nx;
    logic        h_last, frame_last, act, de_d, c0_d, c1_d, fs_d;

    always_comb begin
        h_last     = h_cnt == H_LAST;
        frame_last = h_last && v_cnt == V_LAST;
        act        = state != IDLE;
        // STOP only returns to IDLE once the frame, back porch included, is done
        state_nx   = state == IDLE ? (vif.en ? RUN : IDLE) :
                     vif.en ? RUN :
                     (state == RUN || !frame_last) ? STOP : IDLE;
        h_nx       = (!act || h_last) ? 12'd0 : h_cnt + 12'd1;
        v_nx       = !act ? 12'd0 : !h_last ? v_cnt : (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        de_d       = act && h_cnt < H_ACT && v_cnt < V_ACT;
        c0_d       = (act && h_cnt >= HS_LO && h_cnt < HS_HI) ? H_POL : ~H_POL;
        c1_d       = (act && v_cnt >= VS_LO && v_cnt < VS_HI) ? V_POL : ~V_POL;
        fs_d       = act && h_cnt == 12'd0 && v_cnt == 12'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            h_cnt           <= '0;
            v_cnt           <= '0;
            vif.de          <= 1'b0;
            vif.blanking    <= 1'b1;
            vif.c0          <= ~H_POL;
            vif.c1          <= ~V_POL;
            vif.x           <= '0;
            vif.y           <= '0;
            vif.frame_start <= 1'b0;
            vif.running     <= 1'b0;
        end else begin
            state           <= state_nx;
            h_cnt           <= h_nx;
            v_cnt           <= v_nx;
            vif.de          <= de_d;
            vif.blanking    <= ~de_d;
            vif.c0          <= c0_d;
            vif.c1          <= c1_d;
            vif.x           <= de_d ? h_cnt : 12'd0;
            vif.y           <= de_d ? v_cnt : 12'd0;
            vif.frame_start <= fs_d;
            vif.running     <= act;
        end
    end
endmodule

// File: doc/video_timing_ctrl.md
VIDEO_TIMING_CTRL -- requirements
Module: video_timing_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  H_ACTIVE, 640, visible pixels per line
  H_FP, 16, horizontal front porch (pixels)
  H_SYNC, 96, hsync width (pixels)
  H_BP, 48, horizontal back porch (pixels)
  V_ACTIVE, 480, visible lines per frame
  V_FP, 10, vertical front porch (lines)
  V_SYNC, 2, vsync width (lines)
  V_BP, 33, vertical back porch (lines)
  H_POL, 0, hsync asserted level
  V_POL, 0, vsync asserted level
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  input  1  pixel clock; the only clock
  rst  input  1  reset, synchronous, active-low
  en  input  1  run request
  blanking  output  1  1 outside active area; drives the tsdm blanking input of all three channels
  c0  output  1  hsync level; drives the blue-channel c0
  c1  output  1  vsync level; drives the blue-channel c1
  de  output  1  active video (always the inverse of blanking)
  x  output  12  pixel column, valid when de=1
  y  output  12  pixel line, valid when de=1
  frame_start  output  1  one-cycle pulse at position (0,0)
  running  output  1  1 in states RUN and STOP
REQ-003 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP SHALL each be at most 4096.

Function
REQ-004 Internal counters: h_cnt 0..H_TOTAL-1; v_cnt 0..V_TOTAL-1.
REQ-005 In RUN and STOP, h_cnt SHALL increment every cycle.
  - At H_TOTAL-1, h_cnt SHALL wrap to 0 and v_cnt SHALL increment.
  - When v_cnt is at V_TOTAL-1 at that wrap, v_cnt SHALL wrap to 0.
REQ-006 FSM states SHALL be IDLE, RUN and STOP, with these transitions:
  - IDLE -> RUN when en=1.
  - RUN -> STOP when en=0.
  - STOP -> RUN when en=1; counters SHALL continue without disturbance.
  - STOP -> IDLE at the cycle where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1 and en=0.
  - If en=1 in that cycle, the next state SHALL be RUN.
REQ-007 In IDLE, h_cnt and v_cnt SHALL be held at 0.
REQ-008 All outputs SHALL be registered from (state, h_cnt, v_cnt), so all outputs reflect the same position in the same cycle.
REQ-009 Output decode, for counter position (h, v):
  - de = (h<H_ACTIVE && v<V_ACTIVE).
  - x = h and y = v when de=1; x = 0 and y = 0 when de=0.
  - c0 = H_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~H_POL.
  - c1 = V_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else ~V_POL.
  - vsync is line-granular; it changes at h=0.
REQ-010 In IDLE, the registered outputs SHALL be: de=0, blanking=1, c0=~H_POL, c1=~V_POL, x=0, y=0, frame_start=0, running=0.
REQ-011 Latency: with en sampled high in IDLE at edge N, counters SHALL be at (0,0) from edge N+1, and de=1, frame_start=1, x=0, y=0 SHALL be visible after edge N+2.
REQ-012 frame_start SHALL pulse for exactly one cycle per frame in RUN or STOP, coincident with the output for (0,0).
REQ-013 A frame in progress SHALL never be truncated by en=0; the last output frame SHALL be complete, including its back porch.
REQ-014 running SHALL be registered and SHALL equal 1 in the same cycle as the outputs for the first position after entering RUN.
  - It SHALL drop together with the return of the outputs to the IDLE values.

Reset
REQ-015 With rst=0 at a clock edge: state SHALL become IDLE, counters 0, and all outputs the REQ-010 values.
  - This SHALL hold regardless of en or position, including mid-frame and mid-sync.
REQ-016 Reset SHALL take priority over en.
  - After rst rises, the REQ-011 latency SHALL apply from the first edge at which en=1 is sampled.

Verification
Bench parameters for all scenarios: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=16); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); H_POL=V_POL=0.
REQ-017 Startup: release reset with en=1 -> after 2 edges, frame_start=1, de=1, x=0, y=0.
  - de=1 for 8 cycles per line; c0=0 for exactly 3 cycles starting at h=10.
REQ-018 Frame check: 128-cycle frame -> 32 de cycles.
  - c1=0 for exactly 32 cycles, covering v=5..6.
  - frame_start pulses every 128 cycles.
REQ-019 Graceful stop: drop en at h=3, v=2 -> outputs continue to (15,7), then IDLE values, running=0.
  - No partial frame is produced.
REQ-020 Restart in STOP: drop en, then raise it 10 cycles later -> timing is unbroken; frame_start period stays 128.
REQ-021 Mid-frame reset: rst=0 for 1 cycle at h=11 (c0=0) -> next cycle c0=1, blanking=1, running=0.
  - With en=1, de=1 returns 2 cycles after rst rises.
REQ-022 Boundary: en toggled 0 then 1 in the final cycle (15,7) -> state is RUN and the next frame_start occurs on schedule.
